// File: rtl/bus_responder_pkg.sv
// Shared definitions for the CPU bus target: region codes, FSM states, error data.
// No logic; no latency.
// No flow control.
package bus_responder_pkg;

    localparam logic [2:0]  REG_RAM  = 3'b000;
    localparam logic [2:0]  REG_ROM  = 3'b001;
    localparam logic [2:0]  REG_IO   = 3'b010;
    localparam logic [31:0] ERR_DATA = 32'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_IO   = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/bus_sram.sv
// Single-port synchronous RAM; contents start undefined unless loaded by the environment.
// Read data registered: valid the cycle after the address is presented.
// No backpressure; one access per cycle.
module bus_sram #(
    parameter int    DW        = 32,
    parameter int    AW        = 10,
    parameter string INIT_FILE = ""
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata_q <= mem[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/bus_responder.sv
// CPU bus target: decodes word address into SRAM, ROM, timed I/O port or unmapped space.
// Latency: mem done in cycle 2, unmapped in cycle 1, I/O one cycle after ack or timeout.
// Initiator holds bus_start until bus_done; one transaction in flight at a time.
module bus_responder #(
    parameter int    RAM_AW     = 10,
    parameter int    ROM_AW     = 9,
    parameter string ROM_INIT   = "rom.list",
    parameter int    IO_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [26:0] bus_addr,
    input  logic [31:0] bus_data,
    input  logic        bus_we,
    input  logic        bus_start,
    output logic [31:0] bus_q,
    output logic        bus_done,
    output logic [23:0] io_addr,
    output logic [31:0] io_wdata,
    output logic        io_we,
    output logic        io_req,
    input  logic        io_ack,
    input  logic [31:0] io_rdata,
    output logic        unmapped_err,
    output logic        io_timeout
);
    import bus_responder_pkg::*;

    localparam int         IDX_W  = (RAM_AW > ROM_AW) ? RAM_AW : ROM_AW;
    localparam logic [7:0] TO_LIM = 8'(IO_TIMEOUT);

    state_e             state_q, state_d;
    logic [2:0]         region_q, region_d;
    logic [IDX_W-1:0]   mem_idx_q, mem_idx_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               we_q, we_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [31:0]        bus_q_q, bus_q_d;
    logic               bus_done_q, bus_done_d;
    logic               io_req_q, io_req_d;
    logic [23:0]        io_addr_q, io_addr_d;
    logic [31:0]        io_wdata_q, io_wdata_d;
    logic               io_we_q, io_we_d;
    logic               uerr_q, uerr_d;
    logic               tout_q, tout_d;

    logic [RAM_AW-1:0]  ram_addr;
    logic [ROM_AW-1:0]  rom_addr;
    logic               ram_we;
    logic [31:0]        ram_rdata, rom_rdata;

    // Arrays see the live bus address in IDLE so read data is ready by MEM.
    assign ram_addr = (state_q == ST_IDLE) ? bus_addr[RAM_AW-1:0] : mem_idx_q[RAM_AW-1:0];
    assign rom_addr = (state_q == ST_IDLE) ? bus_addr[ROM_AW-1:0] : mem_idx_q[ROM_AW-1:0];
    assign ram_we   = (state_q == ST_MEM) && we_q && (region_q == REG_RAM);

    bus_sram #(.DW(32), .AW(RAM_AW), .INIT_FILE("")) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    bus_sram #(.DW(32), .AW(ROM_AW), .INIT_FILE(ROM_INIT)) u_rom (
        .clk   (clk),
        .we    (1'b0),
        .addr  (rom_addr),
        .wdata (32'd0),
        .rdata (rom_rdata)
    );

    always_comb begin
        state_d    = state_q;
        region_d   = region_q;
        mem_idx_d  = mem_idx_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        cnt_d      = cnt_q;
        bus_q_d    = bus_q_q;
        bus_done_d = 1'b0;
        io_req_d   = io_req_q;
        io_addr_d  = io_addr_q;
        io_wdata_d = io_wdata_q;
        io_we_d    = io_we_q;
        uerr_d     = uerr_q;
        tout_d     = tout_q;

        case (state_q)
            ST_IDLE: begin
                if (bus_start) begin
                    region_d  = bus_addr[26:24];
                    mem_idx_d = bus_addr[IDX_W-1:0];
                    wdata_d   = bus_data;
                    we_d      = bus_we;
                    cnt_d     = 8'd0;
                    case (bus_addr[26:24])
                        REG_RAM, REG_ROM: state_d = ST_MEM;
                        REG_IO: begin
                            state_d    = ST_IO;
                            io_req_d   = 1'b1;
                            io_addr_d  = bus_addr[23:0];
                            io_wdata_d = bus_data;
                            io_we_d    = bus_we;
                        end
                        default: begin
                            state_d    = ST_DONE;
                            bus_done_d = 1'b1;
                            bus_q_d    = ERR_DATA;
                            uerr_d     = 1'b1;
                        end
                    endcase
                end
            end
            ST_MEM: begin
                state_d    = ST_DONE;
                bus_done_d = 1'b1;
                if (we_q) begin
                    bus_q_d = ERR_DATA;
                end else begin
                    bus_q_d = (region_q == REG_RAM) ? ram_rdata : rom_rdata;
                end
            end
            ST_IO: begin
                // An ack coinciding with the timeout limit still wins.
                if (io_ack) begin
                    state_d    = ST_DONE;
                    bus_done_d = 1'b1;
                    io_req_d   = 1'b0;
                    bus_q_d    = we_q ? ERR_DATA : io_rdata;
                end else if (cnt_q == TO_LIM) begin
                    state_d    = ST_DONE;
                    bus_done_d = 1'b1;
                    io_req_d   = 1'b0;
                    bus_q_d    = ERR_DATA;
                    tout_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            region_q   <= 3'd0;
            mem_idx_q  <= '0;
            wdata_q    <= 32'd0;
            we_q       <= 1'b0;
            cnt_q      <= 8'd0;
            bus_q_q    <= 32'd0;
            bus_done_q <= 1'b0;
            io_req_q   <= 1'b0;
            io_addr_q  <= 24'd0;
            io_wdata_q <= 32'd0;
            io_we_q    <= 1'b0;
            uerr_q     <= 1'b0;
            tout_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            region_q   <= region_d;
            mem_idx_q  <= mem_idx_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            cnt_q      <= cnt_d;
            bus_q_q    <= bus_q_d;
            bus_done_q <= bus_done_d;
            io_req_q   <= io_req_d;
            io_addr_q  <= io_addr_d;
            io_wdata_q <= io_wdata_d;
            io_we_q    <= io_we_d;
            uerr_q     <= uerr_d;
            tout_q     <= tout_d;
        end
    end

    assign bus_q        = bus_q_q;
    assign bus_done     = bus_done_q;
    assign io_req       = io_req_q;
    assign io_addr      = io_addr_q;
    assign io_wdata     = io_wdata_q;
    assign io_we        = io_we_q;
    assign unmapped_err = uerr_q;
    assign io_timeout   = tout_q;

endmodule

// File: tb/tb_bus_responder.sv
// Randomized bench for bus_responder against a transaction-level reference model.
module tb_bus_responder;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [26:0] bus_addr;
    logic [31:0] bus_data;
    logic        bus_we;
    logic        bus_start;
    logic [31:0] bus_q;
    logic        bus_done;
    logic [23:0] io_addr;
    logic [31:0] io_wdata;
    logic        io_we;
    logic        io_req;
    logic        io_ack;
    logic [31:0] io_rdata;
    logic        unmapped_err;
    logic        io_timeout;

    always #5 clk = ~clk;

    bus_responder #(.RAM_AW(4), .ROM_AW(3), .ROM_INIT(""), .IO_TIMEOUT(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus_addr     (bus_addr),
        .bus_data     (bus_data),
        .bus_we       (bus_we),
        .bus_start    (bus_start),
        .bus_q        (bus_q),
        .bus_done     (bus_done),
        .io_addr      (io_addr),
        .io_wdata     (io_wdata),
        .io_we        (io_we),
        .io_req       (io_req),
        .io_ack       (io_ack),
        .io_rdata     (io_rdata),
        .unmapped_err (unmapped_err),
        .io_timeout   (io_timeout)
    );

    int total = 0;
    int bad   = 0;

    logic        chk_en = 1'b0;
    logic        exp_done, exp_req, exp_uerr, exp_to, exp_io_chk, exp_io_we;
    logic [31:0] exp_q, exp_io_wdata;
    logic [23:0] exp_io_addr;

    logic [31:0] ram_m [16];
    logic [31:0] rom_m [8];

    int          cyc;
    int          obs_cyc;
    logic [31:0] obs_q;
    logic [23:0] obs_io_addr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("bus_done", 32'(bus_done), 32'(exp_done));
            chk("bus_q", bus_q, exp_q);
            chk("io_req", 32'(io_req), 32'(exp_req));
            chk("unmapped_err", 32'(unmapped_err), 32'(exp_uerr));
            chk("io_timeout", 32'(io_timeout), 32'(exp_to));
            if (exp_io_chk) begin
                chk("io_addr", 32'(io_addr), 32'(exp_io_addr));
                chk("io_wdata", io_wdata, exp_io_wdata);
                chk("io_we", 32'(io_we), 32'(exp_io_we));
            end
            if (bus_done === 1'b1) begin
                obs_cyc = cyc;
                obs_q   = bus_q;
            end
            if (io_req === 1'b1) obs_io_addr = io_addr;
        end
    end

    // ack_at: cycle of the transaction in which io_ack is driven; honoured only inside the IO window.
    task automatic run_txn(input logic [26:0] a, input logic [31:0] d, input logic w,
                           input int ack_at, input logic [31:0] iord);
        logic [2:0]  rg;
        int          dn;
        logic [31:0] res;
        logic        ack_ok;
        rg     = a[26:24];
        ack_ok = (rg == 3'b010) && (ack_at >= 1) && (ack_at <= TO + 1);
        if (rg == 3'b000 || rg == 3'b001) begin
            dn  = 2;
            res = w ? 32'd0 : ((rg == 3'b000) ? ram_m[a[3:0]] : rom_m[a[2:0]]);
        end else if (rg == 3'b010) begin
            dn  = ack_ok ? ack_at + 1 : TO + 2;
            res = (ack_ok && !w) ? iord : 32'd0;
        end else begin
            dn  = 1;
            res = 32'd0;
        end
        obs_cyc = -1;
        obs_q   = 'x;
        for (int c = 0; c <= dn; c++) begin
            logic in_io;
            in_io     = (rg == 3'b010) && (c >= 1) && (c < dn);
            cyc       = c;
            bus_start = 1'b1;
            bus_addr  = a;
            bus_data  = d;
            bus_we    = w;
            io_ack    = in_io ? (ack_ok && c == ack_at) : 1'($urandom_range(0, 1));
            io_rdata  = (in_io && c == ack_at) ? iord : $urandom;
            exp_req      = in_io;
            exp_done     = (c == dn);
            exp_io_chk   = in_io;
            exp_io_addr  = a[23:0];
            exp_io_wdata = d;
            exp_io_we    = w;
            if (c == dn) begin
                exp_q = res;
                if (rg >= 3'd3) exp_uerr = 1'b1;
                if (rg == 3'b010 && !ack_ok) exp_to = 1'b1;
            end
            step();
        end
        if (rg == 3'b000 && w) ram_m[a[3:0]] = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cyc        = -1;
            bus_start  = 1'b0;
            bus_addr   = 27'($urandom);
            bus_data   = $urandom;
            bus_we     = 1'($urandom_range(0, 1));
            io_ack     = 1'($urandom_range(0, 1));
            io_rdata   = $urandom;
            exp_done   = 1'b0;
            exp_req    = 1'b0;
            exp_io_chk = 1'b0;
            step();
        end
    endtask

    task automatic set_reset_exp();
        exp_done     = 1'b0;
        exp_req      = 1'b0;
        exp_q        = 32'd0;
        exp_uerr     = 1'b0;
        exp_to       = 1'b0;
        exp_io_chk   = 1'b1;
        exp_io_addr  = 24'd0;
        exp_io_wdata = 32'd0;
        exp_io_we    = 1'b0;
    endtask

    // I/O read left unanswered, then reset lands in its third IO cycle.
    task automatic abort_io(input logic [26:0] a);
        for (int c = 0; c <= 3; c++) begin
            cyc          = c;
            bus_start    = 1'b1;
            bus_addr     = a;
            bus_data     = 32'h1111_2222;
            bus_we       = 1'b0;
            io_ack       = (c == 0) ? 1'b1 : 1'b0;
            io_rdata     = $urandom;
            reset        = (c == 3);
            exp_done     = 1'b0;
            exp_req      = (c >= 1);
            exp_io_chk   = (c >= 1);
            exp_io_addr  = a[23:0];
            exp_io_wdata = 32'h1111_2222;
            exp_io_we    = 1'b0;
            step();
        end
        reset     = 1'b0;
        bus_start = 1'b0;
        io_ack    = 1'b0;
        set_reset_exp();
        step();
        exp_io_chk = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        bus_start = 1'b0;
        bus_addr  = 27'd0;
        bus_data  = 32'd0;
        bus_we    = 1'b0;
        io_ack    = 1'b0;
        io_rdata  = 32'd0;
        cyc       = -1;
        for (int i = 0; i < 8; i++) begin
            rom_m[i] = (i == 0) ? 32'h1234_5678 : $urandom;
            dut.u_rom.mem[i] = rom_m[i];
        end
        set_reset_exp();
        step();
        chk_en = 1'b1;
        step();
        reset = 1'b0;
        step();
        exp_io_chk = 1'b0;

        for (int i = 0; i < 16; i++)
            run_txn({3'b000, 20'($urandom), 4'(i)}, $urandom, 1'b1, 0, 32'd0);

        run_txn(27'h000_0005, 32'hCAFE_BABE, 1'b1, 0, 32'd0);
        chk("wr_done_cycle", 32'(obs_cyc), 32'd2);
        chk("wr_q", obs_q, 32'd0);
        run_txn(27'h000_0005, 32'd0, 1'b0, 0, 32'd0);
        chk("rd_done_cycle", 32'(obs_cyc), 32'd2);
        chk("rd_q", obs_q, 32'hCAFE_BABE);

        run_txn(27'h100_0000, 32'd0, 1'b0, 0, 32'd0);
        chk("rom_rd", obs_q, 32'h1234_5678);
        run_txn(27'h100_0000, 32'hFFFF_FFFF, 1'b1, 0, 32'd0);
        chk("rom_wr_q", obs_q, 32'd0);
        run_txn(27'h100_0000, 32'd0, 1'b0, 0, 32'd0);
        chk("rom_rd_after_wr", obs_q, 32'h1234_5678);

        run_txn(27'h200_0010, 32'd0, 1'b0, 4, 32'hA5A5_A5A5);
        chk("io_done_cycle", 32'(obs_cyc), 32'd5);
        chk("io_q", obs_q, 32'hA5A5_A5A5);
        chk("io_addr_lit", 32'(obs_io_addr), 32'h0000_0010);

        run_txn(27'h200_0020, 32'd0, 1'b0, 0, 32'd0);
        chk("to_done_cycle", 32'(obs_cyc), 32'd10);
        chk("to_q", obs_q, 32'd0);
        idle(2);
        chk("to_sticky", 32'(io_timeout), 32'd1);

        run_txn(27'h700_0000, 32'd0, 1'b0, 0, 32'd0);
        chk("unm_done_cycle", 32'(obs_cyc), 32'd1);
        chk("unm_q", obs_q, 32'd0);
        chk("unm_flag", 32'(unmapped_err), 32'd1);
        run_txn(27'h000_0005, 32'd0, 1'b0, 0, 32'd0);
        chk("rd_after_unm", obs_q, 32'hCAFE_BABE);

        abort_io(27'h200_0040);
        idle(2);
        run_txn(27'h000_0005, 32'd0, 1'b0, 0, 32'd0);
        chk("rd_after_reset", obs_q, 32'hCAFE_BABE);

        for (int n = 0; n < 400; n++) begin
            int          r;
            logic [2:0]  rg;
            r = $urandom_range(0, 99);
            if (r < 40)      rg = 3'b000;
            else if (r < 60) rg = 3'b001;
            else if (r < 85) rg = 3'b010;
            else             rg = 3'($urandom_range(3, 7));
            run_txn({rg, 24'($urandom)}, $urandom, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 10), $urandom);
            idle($urandom_range(0, 2));
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
